// File: rtl/reaction_result_uart_tx.sv
// Reaction-time reporter: accepts a 16-bit millisecond result, converts it to
// five ASCII decimal digits by sequential double-dabble and sends "DDDDD\r\n" as 8N1 UART.
module reaction_result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        result_valid,
   input  logic [15:0] result_ms,
   output logic        result_ready,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned BIN_W  = 16;
   localparam int unsigned BCD_W  = 20;
   localparam int unsigned CNT_W  = 16;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [4:0]       ITER_DONE = 5'd16;
   localparam logic [2:0]       LAST_BYTE = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONVERT,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [4:0]         iter_q, iter_d;
   logic [2:0]         byte_idx_q, byte_idx_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;

   logic [BCD_W-1:0]       bcd_adj;
   logic [BCD_W+BIN_W-1:0] dabble;
   logic [7:0]             cur_byte;
   logic                   bit_tick;

   // State register; reset forces the line idle and abandons any frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         clk_cnt_q  <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         clk_cnt_q  <= clk_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      dabble = {bcd_adj, bin_q} << 1;
   end

   // Byte currently being framed: five digits MSD first, then CR, LF
   always_comb begin
      cur_byte = 8'h0A;
      case (byte_idx_q)
         3'd0:    cur_byte = 8'h30 + {4'h0, bcd_q[19:16]};
         3'd1:    cur_byte = 8'h30 + {4'h0, bcd_q[15:12]};
         3'd2:    cur_byte = 8'h30 + {4'h0, bcd_q[11:8]};
         3'd3:    cur_byte = 8'h30 + {4'h0, bcd_q[7:4]};
         3'd4:    cur_byte = 8'h30 + {4'h0, bcd_q[3:0]};
         3'd5:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   assign bit_tick = (clk_cnt_q == BIT_LAST);

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      clk_cnt_d  = clk_cnt_q;
      tx_d       = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (result_valid) begin
               bin_d   = result_ms;
               bcd_d   = '0;
               iter_d  = '0;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            if (iter_q == ITER_DONE) begin
               byte_idx_d = '0;
               clk_cnt_d  = '0;
               state_d    = S_START;
            end else begin
               bcd_d  = dabble[BCD_W+BIN_W-1:BIN_W];
               bin_d  = dabble[BIN_W-1:0];
               iter_d = iter_q + 5'd1;
            end
         end
         S_START: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               if (byte_idx_q == LAST_BYTE) begin
                  state_d = S_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = S_START;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line level registered alongside the state it belongs to
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = cur_byte[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   assign busy_d  = (state_d != S_IDLE);
   assign ready_d = (state_d == S_IDLE);

   assign tx           = tx_q;
   assign busy         = busy_q;
   assign result_ready = ready_q;

endmodule

// File: tb/tb_reaction_result_uart_tx.sv
// Bench for reaction_result_uart_tx: captures the line every cycle, decodes
// 8N1 frames with exact bit-period checking and compares against a decimal model.
module tb_reaction_result_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_a = 1'b0, valid_b = 1'b0;
   logic [15:0] ms_a = '0, ms_b = '0;
   logic        ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;

   reaction_result_uart_tx #(.CLKS_PER_BIT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .result_valid(valid_a), .result_ms(ms_a),
      .result_ready(ready_a), .tx(tx_a), .busy(busy_a));

   reaction_result_uart_tx #(.CLKS_PER_BIT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .result_valid(valid_b), .result_ms(ms_b),
      .result_ready(ready_b), .tx(tx_b), .busy(busy_b));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit sel_b  = 1'b0;

   bit smp [0:1023];
   bit bsy [0:1023];
   bit rdy [0:1023];
   int ncap = 0;
   int rx_q[$];
   int st_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of v by arithmetic, then CR LF
   function automatic int ref_byte(input int v, input int k);
      int div;
      case (k)
         0: div = 10000;
         1: div = 1000;
         2: div = 100;
         3: div = 10;
         4: div = 1;
         5: return 13;
         default: return 10;
      endcase
      return 48 + (v / div) % 10;
   endfunction

   task automatic capture(input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         if (ncap < 1024) begin
            smp[ncap] = sel_b ? tx_b : tx_a;
            bsy[ncap] = sel_b ? busy_b : busy_a;
            rdy[ncap] = sel_b ? ready_b : ready_a;
            ncap++;
         end
      end
   endtask

   // Offer v; returns just after the transfer edge with the capture cleared
   task automatic send(input int v, input bit hold);
      @(negedge clk);
      if (sel_b) begin valid_b = 1'b1; ms_b = 16'(v); end
      else       begin valid_a = 1'b1; ms_a = 16'(v); end
      @(posedge clk);
      #1;
      if (!hold) begin valid_a = 1'b0; valid_b = 1'b0; end
      ncap = 0;
   endtask

   task automatic decode(input int cpb);
      int i = 0;
      rx_q.delete();
      st_q.delete();
      while (i < ncap) begin
         if (smp[i] == 1'b0) begin
            int b = 0;
            int ok = 1;
            chk("frame_fits", int'(i + 10*cpb <= ncap), 1);
            if (i + 10*cpb > ncap) break;
            for (int k = 0; k < 10; k++)
               for (int s = 1; s < cpb; s++)
                  if (smp[i + k*cpb + s] != smp[i + k*cpb]) ok = 0;
            if (smp[i + 9*cpb] != 1'b1) ok = 0;
            for (int d = 0; d < 8; d++)
               if (smp[i + (d+1)*cpb]) b |= (1 << d);
            chk($sformatf("frame_shape@%0d", i), ok, 1);
            rx_q.push_back(b);
            st_q.push_back(i);
            i += 10*cpb;
         end else begin
            i++;
         end
      end
   endtask

   task automatic check_line(input string tag, input int v, input int base);
      for (int k = 0; k < 7; k++) begin
         int obs = (base + k < rx_q.size()) ? rx_q[base + k] : -1;
         chk($sformatf("%s_byte%0d", tag, k), obs, ref_byte(v, k));
      end
   endtask

   function automatic int first_low();
      for (int j = 0; j < ncap; j++) if (smp[j] == 1'b0) return j;
      return -1;
   endfunction

   function automatic int count_busy();
      int c = 0;
      for (int j = 0; j < ncap; j++) if (bsy[j]) c++;
      return c;
   endfunction

   task automatic one_msg(input string tag, input int v, input int cpb);
      send(v, 1'b0);
      capture(17 + 70*cpb + 8);
      decode(cpb);
      chk({tag, "_nbytes"}, rx_q.size(), 7);
      check_line(tag, v, 0);
   endtask

   initial begin
      int r;
      int c;

      // Reset state
      #12;
      chk("rst_tx", int'(tx_a), 1);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_ready", int'(ready_a), 1);
      chk("rst_tx_b", int'(tx_b), 1);
      @(negedge clk);
      rst_n = 1'b1;
      capture(2);
      chk("idle_tx", int'(smp[1]), 1);

      // 1234 with single-cycle valid: latency, busy length, content
      send(1234, 1'b0);
      capture(310);
      chk("busy_after_xfer", int'(bsy[0]), 1);
      chk("ready_after_xfer", int'(rdy[0]), 0);
      chk("start_latency", first_low(), 17);
      chk("busy_cycles", count_busy(), 17 + 280);
      chk("ready_back", int'(rdy[297]), 1);
      decode(4);
      chk("m1234_nbytes", rx_q.size(), 7);
      check_line("m1234", 1234, 0);

      // Boundary values and random values
      one_msg("v0", 0, 4);
      one_msg("v65535", 65535, 4);
      one_msg("v9", 9, 4);
      one_msg("v10000", 10000, 4);
      for (int n = 0; n < 3; n++) one_msg($sformatf("rnd%0d", n), int'($urandom_range(0, 65535)), 4);

      // Valid held high: 42 then 7, minimum inter-message gap
      send(42, 1'b1);
      capture(200);
      ms_a = 16'd7;
      capture(200);
      valid_a = 1'b0;
      capture(240);
      decode(4);
      chk("held_nbytes", rx_q.size(), 14);
      check_line("held42", 42, 0);
      check_line("held7", 7, 7);
      chk("held_gap", (st_q.size() >= 8) ? st_q[7] - (st_q[6] + 40) : -1, 18);

      // Pulses during CONVERT and DATA are ignored
      r = int'($urandom_range(0, 65535));
      send(r, 1'b0);
      capture(3);
      valid_a = 1'b1; ms_a = 16'd999;
      capture(1);
      valid_a = 1'b0;
      capture(20);
      valid_a = 1'b1; ms_a = 16'd999;
      capture(1);
      valid_a = 1'b0;
      capture(320);
      c = 0;
      for (int j = 0; j < 297; j++) if (rdy[j]) c++;
      chk("ignore_ready_low", c, 0);
      decode(4);
      chk("ignore_nbytes", rx_q.size(), 7);
      check_line("ignore", r, 0);

      // Reset in the middle of byte 2 data bits
      send(int'($urandom_range(0, 65535)), 1'b0);
      capture(115);
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", int'(tx_a), 1);
      chk("midrst_busy", int'(busy_a), 0);
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      send(5, 1'b0);
      capture(305);
      chk("postrst_latency", first_low(), 17);
      decode(4);
      chk("postrst_nbytes", rx_q.size(), 7);
      check_line("postrst", 5, 0);

      // Minimum bit time on the second instance
      sel_b = 1'b1;
      send(31415, 1'b0);
      capture(17 + 140 + 8);
      chk("b_latency", first_low(), 17);
      chk("b_busy_cycles", count_busy(), 17 + 140);
      decode(2);
      chk("b31415_nbytes", rx_q.size(), 7);
      check_line("b31415", 31415, 0);
      one_msg("b_rnd", int'($urandom_range(0, 65535)), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reaction_result_uart_tx.md
# reaction_result_uart_tx

Serial reporting block for the reaction-time tester. It accepts one measured reaction time (16-bit, milliseconds) through a valid/ready handshake and converts it to five ASCII decimal digits with a sequential double-dabble. It then transmits the line "DDDDD\r\n" as seven 8N1 UART frames on a single output pin, the transmit end of the link read by the host or bench. It sits between the reaction-time measurement logic and a `uio_out` pin of the top level.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `result_valid`  in  1  a result is offered on `result_ms`.
- `result_ms`  in  16  reaction time in ms, unsigned, 0..65535.
- `result_ready`  out  1  block can accept a result; equals (state == IDLE).
- `tx`  out  1  UART line, idle high, LSB first, 8N1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: state IDLE, `tx`=1, `busy`=0, `result_ready`=1.
  - `result_valid` is ignored while `rst_n` is low.
- IDLE
  - Transfer occurs on a rising edge where `result_valid && result_ready`.
  - On transfer: capture `result_ms` into a 16-bit shift register, clear the 20-bit BCD register, go to CONVERT.
- CONVERT (double-dabble), 16 iterations:
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1.
  - After the 16th iteration go to START, with byte index 0.
- Byte sequence, index 0..6:
  - Index 0..4: ASCII digits, most significant first (0x30 + nibble). Leading zeros are sent: 7 → "00007".
  - Index 5: 0x0D.
  - Index 6: 0x0A.
- Frame states:
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: bits 0..7 LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
- After STOP:
  - If index < 6: increment index and go to START. There is no idle gap between frames.
  - If index = 6: return to IDLE.
- `result_valid` is ignored in every non-IDLE state. Results are never queued or overwritten mid-transmission.
- `tx` is driven from a register, so it carries no combinational glitches.
- The bit counter is 16 bits wide and counts 0..CLKS_PER_BIT-1; it wraps to 0 at each bit boundary.

## Timing
- Let E0 be the transfer edge. `busy`=1 and `result_ready`=0 are visible right after E0.
- CONVERT spans edges E0+1..E0+16.
- `tx` falls (start bit of byte 0) right after edge E0+17.
- Each frame lasts 10×CLKS_PER_BIT cycles. The message lasts 70×CLKS_PER_BIT cycles.
- The return to IDLE happens on the edge that ends the last stop bit, at E0+17+70×CLKS_PER_BIT.
  - `result_ready`=1 right after that edge.
  - With `result_valid` held high, the next transfer occurs on the following edge. Minimum message-to-message line idle is therefore 18 cycles (1 transfer edge + 16 CONVERT + 1 START entry).
- Reset mid-operation (any state, any bit):
  - `tx` goes high and `busy` goes low asynchronously.
  - The partial frame is abandoned; no resumption after reset release.
  - The first transfer is possible on the first rising edge with `rst_n` high.
- Simultaneous `result_valid` rise and exit to IDLE: not accepted on that edge (ready was 0). Accepted on the next edge.

## Test plan
- CLKS_PER_BIT=4, `result_ms`=1234, single-cycle valid.
  - Bench UART decoder receives 0x30 0x31 0x32 0x33 0x34 0x0D 0x0A.
  - `tx` falls exactly 17 cycles after the transfer edge.
  - `busy` high for 17+280 cycles.
- Boundary values, each sent as one message:
  - 0 → "00000\r\n".
  - 65535 → "65535\r\n".
  - 9 → "00009\r\n".
  - 10000 → "10000\r\n".
- `result_valid` held high with `result_ms`=42, then changed to 7 during transmission.
  - Exactly "00042\r\n" followed by "00007\r\n".
  - Second start bit begins 18 cycles after the first message's last stop bit ends.
- Pulse `result_valid` with 999 during CONVERT and again during DATA.
  - Both pulses ignored; only the original message is sent, and `result_ready` stays 0.
- Assert `rst_n`=0 in the middle of byte 2's DATA phase.
  - `tx`=1 and `busy`=0 immediately.
  - After release, send 5 → clean "00005\r\n" with no residual bits.
- CLKS_PER_BIT=2, value 31415 → "31415\r\n" with exactly 2-cycle bit periods, checking the minimum legal bit time.
